// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral endpoint, MSB first, 8-bit frames.
// Pins are oversampled in i_clk; bytes stream back-to-back under one CS.
module spi_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_spi_clk,
    input  logic       i_spi_cs_n,
    input  logic       i_spi_mosi,
    output logic       o_spi_miso,
    output logic       o_spi_miso_oe,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_dv,
    output logic       o_tx_ready,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_tx_underrun
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic [0:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic       r_byte_done;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic       r_spi_miso;
    logic       r_spi_miso_oe;
    logic       r_rx_dv;
    logic [7:0] r_rx_byte;
    logic       r_tx_underrun;

    logic       w_sclk;
    logic       w_cs_n;
    logic       w_mosi;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_load;
    logic [7:0] w_load_byte;

    // Synchronize SPI pins; CS idles high, SCLK idles low
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
        end
    end

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // Delayed copies of synchronized SCLK / CS_n for edge detection
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b1;
        end else begin
            r_sclk_d <= w_sclk;
            r_cs_d   <= w_cs_n;
        end
    end

    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_fall   = ~w_cs_n & r_cs_d;
    assign w_cs_rise   = w_cs_n & ~r_cs_d;

    // A byte loads at frame start and on the SCLK fall that ends a byte;
    // a CS rise in the same cycle cancels the SCLK-driven load.
    assign w_load = ((r_state == S_IDLE) && w_cs_fall)
                  || ((r_state == S_ACTIVE) && !w_cs_rise
                      && w_sclk_fall && r_byte_done);
    assign w_load_byte = r_hold_full ? r_hold : IDLE_BYTE;

    // TX holding register: a load sees the old state, so a byte written
    // in the same cycle as an empty-load is kept for the following byte
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
        end else if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (i_tx_dv && !r_hold_full) begin
            r_hold      <= i_tx_byte;
            r_hold_full <= 1'b1;
        end
    end

    // Frame FSM, RX/TX shifters and output pulses
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= 3'd0;
            r_rx_shift    <= 8'h00;
            r_tx_shift    <= 8'h00;
            r_byte_done   <= 1'b0;
            r_spi_miso    <= 1'b1;
            r_spi_miso_oe <= 1'b0;
            r_rx_dv       <= 1'b0;
            r_rx_byte     <= 8'h00;
            r_tx_underrun <= 1'b0;
        end else begin
            r_rx_dv       <= 1'b0;
            r_tx_underrun <= 1'b0;
            if (w_load) begin
                r_tx_shift    <= w_load_byte;
                r_spi_miso    <= w_load_byte[7];
                r_tx_underrun <= ~r_hold_full;
            end
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= 3'd0;
                    if (w_cs_fall) begin
                        r_state       <= S_ACTIVE;
                        r_spi_miso_oe <= 1'b1;
                        r_byte_done   <= 1'b0;
                        r_rx_shift    <= 8'h00;
                    end
                end
                S_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state       <= S_IDLE;
                        r_bit_cnt     <= 3'd0;
                        r_byte_done   <= 1'b0;
                        r_rx_shift    <= 8'h00;
                        r_spi_miso_oe <= 1'b0;
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= {r_rx_shift[6:0], w_mosi};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_byte   <= {r_rx_shift[6:0], w_mosi};
                            r_rx_dv     <= 1'b1;
                            r_byte_done <= 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        if (r_byte_done) begin
                            r_byte_done <= 1'b0;
                        end else begin
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                            r_spi_miso <= r_tx_shift[6];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_spi_miso    = r_spi_miso;
    assign o_spi_miso_oe = r_spi_miso_oe;
    assign o_tx_ready    = ~r_hold_full;
    assign o_rx_dv       = r_rx_dv;
    assign o_rx_byte     = r_rx_byte;
    assign o_tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: acts as a mode-0 SPI controller
// and checks MISO, RX delivery, TX holding and underrun behaviour.
module tb_spi_peripheral;

    localparam int HP = 8;

    logic       i_clk;
    logic       i_reset_n;
    logic       i_spi_clk;
    logic       i_spi_cs_n;
    logic       i_spi_mosi;
    logic       o_spi_miso;
    logic       o_spi_miso_oe;
    logic [7:0] i_tx_byte;
    logic       i_tx_dv;
    logic       o_tx_ready;
    logic       o_rx_dv;
    logic [7:0] o_rx_byte;
    logic       o_tx_underrun;

    spi_peripheral #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_spi_clk     (i_spi_clk),
        .i_spi_cs_n    (i_spi_cs_n),
        .i_spi_mosi    (i_spi_mosi),
        .o_spi_miso    (o_spi_miso),
        .o_spi_miso_oe (o_spi_miso_oe),
        .i_tx_byte     (i_tx_byte),
        .i_tx_dv       (i_tx_dv),
        .o_tx_ready    (o_tx_ready),
        .o_rx_dv       (o_rx_dv),
        .o_rx_byte     (o_rx_byte),
        .o_tx_underrun (o_tx_underrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_hist[$];
    int         un_tot = 0;

    // Record every RX pulse and underrun pulse away from the active edge
    always @(negedge i_clk) begin
        if (o_rx_dv) rx_hist.push_back(o_rx_byte);
        if (o_tx_underrun) un_tot++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic tx_load(input logic [7:0] b);
        @(posedge i_clk);
        #1;
        i_tx_byte = b;
        i_tx_dv   = 1'b1;
        @(posedge i_clk);
        #1;
        i_tx_dv   = 1'b0;
    endtask

    // One CS assertion of nbits SCLK rises; mosi/miso are left-aligned.
    // CS is raised while SCLK is still high, so no trailing fall is seen.
    task automatic frame(input int nbits, input logic [15:0] mosi,
                         input int inj_at, input logic [7:0] injb,
                         output logic [15:0] miso);
        miso = '0;
        i_spi_cs_n = 1'b0;
        wt(HP);
        for (int i = 0; i < nbits; i++) begin
            i_spi_mosi = mosi[15-i];
            if (i == inj_at) tx_load(injb);
            wt(HP);
            miso[15-i] = o_spi_miso;
            i_spi_clk = 1'b1;
            wt(HP);
            if (i != nbits - 1) i_spi_clk = 1'b0;
        end
        i_spi_cs_n = 1'b1;
        wt(HP);
        i_spi_clk = 1'b0;
        wt(HP);
    endtask

    logic [15:0] mo;
    int          rx0;
    int          un0;

    initial begin
        i_reset_n  = 1'b0;
        i_spi_clk  = 1'b0;
        i_spi_cs_n = 1'b1;
        i_spi_mosi = 1'b0;
        i_tx_byte  = 8'h00;
        i_tx_dv    = 1'b0;
        wt(3);
        check("rst_miso", o_spi_miso, 1);
        check("rst_oe", o_spi_miso_oe, 0);
        check("rst_rxdv", o_rx_dv, 0);
        check("rst_rxbyte", o_rx_byte, 8'h00);
        check("rst_ready", o_tx_ready, 1);
        check("rst_under", o_tx_underrun, 0);
        i_reset_n = 1'b1;
        wt(4);

        // Single frame
        tx_load(8'hA5);
        check("single_ready_lo", o_tx_ready, 0);
        rx0 = rx_hist.size();
        un0 = un_tot;
        frame(8, 16'h3C00, -1, 8'h00, mo);
        check("single_miso", mo[15:8], 8'hA5);
        check("single_rxcnt", rx_hist.size() - rx0, 1);
        check("single_rxbyte", o_rx_byte, 8'h3C);
        check("single_under", un_tot - un0, 0);
        check("single_ready_hi", o_tx_ready, 1);
        check("single_oe_off", o_spi_miso_oe, 0);

        // Back-to-back bytes, second byte loaded during the first
        tx_load(8'h01);
        rx0 = rx_hist.size();
        un0 = un_tot;
        frame(16, 16'hF00F, 3, 8'h02, mo);
        check("b2b_miso", mo, 16'h0102);
        check("b2b_rxcnt", rx_hist.size() - rx0, 2);
        check("b2b_rx0", rx_hist[rx0], 8'hF0);
        check("b2b_rx1", rx_hist[rx0+1], 8'h0F);
        check("b2b_under", un_tot - un0, 0);

        // Underrun
        un0 = un_tot;
        frame(16, 16'h1234, -1, 8'h00, mo);
        check("under_miso", mo, 16'hFFFF);
        check("under_cnt", un_tot - un0, 2);

        // Abort after 5 rises, then a clean frame
        rx0 = rx_hist.size();
        frame(5, 16'hFF00, -1, 8'h00, mo);
        check("abort_rxcnt", rx_hist.size() - rx0, 0);
        check("abort_oe", o_spi_miso_oe, 0);
        frame(8, 16'h8100, -1, 8'h00, mo);
        check("after_abort_cnt", rx_hist.size() - rx0, 1);
        check("after_abort_rx", o_rx_byte, 8'h81);

        // Holding register is not overwritten while full
        tx_load(8'h11);
        check("hold_ready_lo", o_tx_ready, 0);
        tx_load(8'h22);
        frame(8, 16'h7700, -1, 8'h00, mo);
        check("hold_miso", mo[15:8], 8'h11);
        check("hold_rx", o_rx_byte, 8'h77);
        check("hold_ready_hi", o_tx_ready, 1);

        // Reset mid-byte after 3 rises
        i_spi_cs_n = 1'b0;
        wt(HP);
        for (int i = 0; i < 3; i++) begin
            i_spi_mosi = 1'b1;
            wt(HP);
            i_spi_clk = 1'b1;
            wt(HP);
            if (i != 2) i_spi_clk = 1'b0;
        end
        check("mid_oe_on", o_spi_miso_oe, 1);
        i_reset_n = 1'b0;
        #1;
        check("mrst_miso", o_spi_miso, 1);
        check("mrst_oe", o_spi_miso_oe, 0);
        check("mrst_rxdv", o_rx_dv, 0);
        check("mrst_rxbyte", o_rx_byte, 8'h00);
        check("mrst_ready", o_tx_ready, 1);
        check("mrst_under", o_tx_underrun, 0);
        i_spi_clk  = 1'b0;
        i_spi_cs_n = 1'b1;
        wt(3);
        i_reset_n = 1'b1;
        wt(4);
        rx0 = rx_hist.size();
        frame(8, 16'h5A00, -1, 8'h00, mo);
        check("post_rst_cnt", rx_hist.size() - rx0, 1);
        check("post_rst_rx", o_rx_byte, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI peripheral (slave) endpoint, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, for the SPI controller block in this design. It oversamples the external SPI pins in the i_clk domain. It delivers each received MOSI byte to local logic with a one-cycle valid pulse. It shifts out a locally supplied byte on MISO in the same frame. It runs back-to-back bytes within one chip-select assertion and drives a tri-state enable for a shared MISO line.

## Interface
- SYNC_STAGES, 2, synchronizer depth for i_spi_clk, i_spi_cs_n, i_spi_mosi (legal ≥2).
- IDLE_BYTE, 8'hFF, byte shifted out when no TX byte is pending.

- i_clk  input  1  system clock.
- i_reset_n  input  1  reset; asynchronous, active-low.
- i_spi_clk  input  1  SPI clock from controller; idles low.
- i_spi_cs_n  input  1  chip select, active-low.
- i_spi_mosi  input  1  controller-out serial data.
- o_spi_miso  output  1  peripheral-out serial data.
- o_spi_miso_oe  output  1  MISO driver enable; high only while selected.
- i_tx_byte  input  8  next byte to send.
- i_tx_dv  input  1  load pulse for i_tx_byte.
- o_tx_ready  output  1  TX holding register empty.
- o_rx_dv  output  1  one-cycle pulse: o_rx_byte updated.
- o_rx_byte  output  8  last complete received byte; held until the next byte completes.
- o_tx_underrun  output  1  one-cycle pulse: IDLE_BYTE substituted for a missing TX byte.

## Operation
- Synchronization: each SPI input passes through SYNC_STAGES flops. One further register on the synchronized SCLK and CS_n gives edge detection: sclk_rise, sclk_fall, cs_fall, cs_rise.
- State machine with two states.
  - IDLE: synchronized CS_n is high. The bit counter is held at 0 and SCLK edges are ignored.
  - ACTIVE: entered on cs_fall and left on cs_rise.
- Frame-start byte load occurs on cs_fall.
  - tx_shift loads the holding register if it is full, and the holding register is then marked empty.
  - Otherwise tx_shift loads IDLE_BYTE and o_tx_underrun pulses.
  - o_spi_miso is set to bit 7 of the loaded value and o_spi_miso_oe is set to 1.
- Each sclk_rise in ACTIVE:
  - rx_shift becomes {rx_shift[6:0], mosi} and bit_cnt increments, wrapping 7→0.
  - When bit_cnt was 7, o_rx_byte takes {rx_shift[6:0], mosi}, o_rx_dv pulses, and byte_done is set.
- Each sclk_fall in ACTIVE:
  - If byte_done is set, the next byte loads exactly as at frame start, o_spi_miso takes the new bit 7, and byte_done clears.
  - Otherwise tx_shift shifts left and o_spi_miso takes the next bit.
- cs_rise (abort or end of frame):
  - Return to IDLE, clear bit_cnt and byte_done, discard any partial rx_shift with no o_rx_dv, and drive o_spi_miso_oe to 0.
  - A partial tx_shift is discarded. The holding register is left unchanged.
- Holding register:
  - i_tx_dv while o_tx_ready=1 captures i_tx_byte, and o_tx_ready goes to 0 on the next cycle.
  - i_tx_dv while o_tx_ready=0 is ignored; the held byte is not overwritten.
- Simultaneous i_tx_dv and byte load in the same cycle:
  - The load sees the old holding state. If empty, IDLE_BYTE is sent with an underrun pulse.
  - The new byte is captured into the holding register for the next byte.
- Simultaneous cs_rise with sclk_rise or sclk_fall: cs_rise wins and the SCLK edge is ignored.
- Reset values: o_spi_miso=1, o_spi_miso_oe=0, o_rx_dv=0, o_rx_byte=8'h00, o_tx_ready=1, o_tx_underrun=0. The state resets to IDLE, all shift registers and counters to 0, and the synchronizers to CS_n=1, SCLK=0.
- Reset asserted mid-frame: all outputs return immediately (asynchronously) to their reset values. After release, the block waits for a new cs_fall.

## Timing
- Input-to-action latency: SYNC_STAGES+1 i_clk rising edges after the first edge that samples the new pin level.
- o_rx_dv is high for exactly 1 cycle per completed byte, with the same latency from the 8th SCLK rising edge.
- o_rx_byte is valid from the o_rx_dv cycle until the next completed byte.
- MISO update: SYNC_STAGES+1 i_clk edges after the SCLK falling edge, or after the CS_n falling edge for the first bit.
- Controller constraints:
  - SCLK high and low phases each ≥ SYNC_STAGES+3 i_clk periods.
  - CS_n falling edge to first SCLK rise ≥ SYNC_STAGES+3 i_clk periods.
- Next TX byte deadline: i_tx_dv no later than the cycle that detects the 8th sclk_rise of the current byte.
- Back-to-back bytes need no gap beyond the normal SCLK low phase.

## Test plan
- Single frame: load 8'hA5, drop CS, and clock MOSI 8'h3C.
  - MISO bits are 1,0,1,0,0,1,0,1.
  - o_rx_dv pulses once with o_rx_byte=8'h3C, o_tx_underrun stays 0, and o_tx_ready returns to 1 at CS fall.
- Back-to-back: load 8'h01, then 8'h02 during byte 1, and send MOSI 8'hF0, 8'h0F in one CS assertion.
  - MISO carries 01 then 02.
  - Two o_rx_dv pulses: F0, then 0F.
- Underrun: no TX byte loaded and 2 bytes clocked. MISO sends FF, FF and o_tx_underrun pulses twice.
- Abort: raise CS after 5 SCLK edges, then run a full frame with MOSI 8'h81.
  - No o_rx_dv at the abort and o_spi_miso_oe drops to 0.
  - The next frame receives exactly 8'h81.
- Holding register: two i_tx_dv pulses (8'h11, then 8'h22) while o_tx_ready=0, then one frame. MISO sends 8'h11 and 8'h22 is never sent.
- Reset mid-byte after 3 SCLK rises:
  - All outputs take their reset values immediately.
  - The next full frame receives MOSI 8'h5A correctly.
